// File: rtl/d_lock_defs.sv
// Shared definitions for the keypad passcode checker: FSM encoding, sizes, defaults.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package d_lock_defs;

    localparam int          PW_LEN_DEF     = 4;
    localparam int          CNT_W          = 3;
    localparam int          ERR_W          = 3;
    localparam logic [15:0] DEFAULT_PW_DEF = 16'h1234;
    localparam logic [2:0]  ERR_MAX_DEF    = 3'd7;
    localparam logic [3:0]  KEY_MAX_DIGIT  = 4'd9;

    typedef enum logic [2:0] {
        ST_ENTRY  = 3'd0,
        ST_CHECK  = 3'd1,
        ST_GRANT  = 3'd2,
        ST_DENY   = 3'd3,
        ST_SET    = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    // Saturating increment for the wrong-submission counter.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val,
                                                  input logic [ERR_W-1:0] max_val);
        return (val >= max_val) ? max_val : val + ERR_W'(1);
    endfunction

endpackage

// File: rtl/d_digit_buffer.sv
// BCD digit shift buffer with fill count and sticky overflow flag.
// Latency: one cycle from clr/shift strobe to updated outputs.
// Backpressure: none; shifts past PW_LEN digits only set ovf, buffer is kept.
module d_digit_buffer
    import d_lock_defs::*;
#(
    parameter int PW_LEN = PW_LEN_DEF
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                clr,
    input  logic                shift_vld,
    input  logic [3:0]          shift_dat,
    output logic [PW_LEN*4-1:0] dig_dat,
    output logic [CNT_W-1:0]    cnt,
    output logic                ovf
);

    logic [PW_LEN*4-1:0] dig_q, dig_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    // Clear wins over shift; a full buffer records overflow instead of shifting.
    always_comb begin
        dig_d = dig_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            dig_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (shift_vld) begin
            if (cnt_q < CNT_W'(PW_LEN)) begin
                dig_d = {dig_q[PW_LEN*4-5:0], shift_dat};
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Buffer state registers, synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            dig_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            dig_q <= dig_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign dig_dat = dig_q;
    assign cnt     = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/d_module_passcheck.sv
// Keypad passcode checker: collects digits, grants/denies, and captures new passcodes.
// Latency: enter->enb_lock 2 cycles; enter->error_counter 2, ->gen_stop 3; set-enter->pw_updated 2.
// Backpressure: none; key strobes are dropped while block_inp or in CHECK/DENY/COMMIT.
module d_module_passcheck
    import d_lock_defs::*;
#(
    parameter int                  PW_LEN     = PW_LEN_DEF,
    parameter logic [PW_LEN*4-1:0] DEFAULT_PW = DEFAULT_PW_DEF,
    parameter logic [ERR_W-1:0]    ERR_MAX    = ERR_MAX_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             key_enter,
    input  logic             key_clear,
    input  logic             key_set,
    input  logic             block_inp,
    input  logic             enb_set,
    input  logic             idle,
    output logic             enb_lock,
    output logic             gen_stop,
    output logic [ERR_W-1:0] error_counter,
    output logic [CNT_W-1:0] digit_cnt,
    output logic             pw_updated
);

    state_t              state_q, state_d;
    logic                enb_lock_q, enb_lock_d;
    logic                gen_stop_q, gen_stop_d;
    logic                pw_updated_q, pw_updated_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [PW_LEN*4-1:0] stored_q, stored_d;

    logic                ent_clr, ent_shift, set_clr, set_shift;
    logic [PW_LEN*4-1:0] ent_dat, set_dat;
    logic [CNT_W-1:0]    ent_cnt, set_cnt;
    logic                ent_ovf, set_ovf;
    logic                digit_ok, ent_match, set_full;

    assign digit_ok  = (key_code <= KEY_MAX_DIGIT);
    assign ent_match = (ent_cnt == CNT_W'(PW_LEN)) && !ent_ovf && (ent_dat == stored_q);
    assign set_full  = (set_cnt == CNT_W'(PW_LEN)) && !set_ovf;

    d_digit_buffer #(.PW_LEN(PW_LEN)) u_entry_buf (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (ent_clr),
        .shift_vld (ent_shift),
        .shift_dat (key_code),
        .dig_dat   (ent_dat),
        .cnt       (ent_cnt),
        .ovf       (ent_ovf)
    );

    d_digit_buffer #(.PW_LEN(PW_LEN)) u_set_buf (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (set_clr),
        .shift_vld (set_shift),
        .shift_dat (key_code),
        .dig_dat   (set_dat),
        .cnt       (set_cnt),
        .ovf       (set_ovf)
    );

    // Next state and outputs; idle overrides everything, then block_inp, then strobes in priority order.
    always_comb begin
        state_d      = state_q;
        enb_lock_d   = enb_lock_q;
        gen_stop_d   = 1'b0;
        pw_updated_d = 1'b0;
        err_d        = err_q;
        stored_d     = stored_q;
        ent_clr      = 1'b0;
        ent_shift    = 1'b0;
        set_clr      = 1'b0;
        set_shift    = 1'b0;
        if (idle) begin
            state_d    = ST_ENTRY;
            enb_lock_d = 1'b0;
            ent_clr    = 1'b1;
            set_clr    = 1'b1;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (!block_inp) begin
                        if (key_enter) begin
                            state_d = ST_CHECK;
                        end else if (key_clear) begin
                            ent_clr = 1'b1;
                        end else if (key_valid && !key_set && digit_ok) begin
                            ent_shift = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    ent_clr = ent_match;
                    if (ent_match) begin
                        state_d    = ST_GRANT;
                        enb_lock_d = 1'b1;
                        err_d      = '0;
                    end else begin
                        state_d = ST_DENY;
                        err_d   = sat_inc(err_q, ERR_MAX);
                    end
                end
                ST_DENY: begin
                    gen_stop_d = 1'b1;
                    ent_clr    = 1'b1;
                    state_d    = ST_ENTRY;
                end
                ST_GRANT: begin
                    if (!block_inp && !key_enter && !key_clear && key_set && enb_set) begin
                        state_d = ST_SET;
                        set_clr = 1'b1;
                    end
                end
                ST_SET: begin
                    if (!enb_set) begin
                        set_clr = 1'b1;
                        state_d = ST_GRANT;
                    end else if (!block_inp) begin
                        if (key_enter) begin
                            set_clr = !set_full;
                            state_d = set_full ? ST_COMMIT : ST_GRANT;
                        end else if (key_clear) begin
                            set_clr = 1'b1;
                        end else if (key_valid && !key_set && digit_ok) begin
                            set_shift = 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    stored_d     = set_dat;
                    pw_updated_d = 1'b1;
                    set_clr      = 1'b1;
                    state_d      = ST_GRANT;
                end
                default: begin
                    state_d = ST_ENTRY;
                end
            endcase
        end
    end

    // Control and output registers, synchronous reset to the default passcode.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= ST_ENTRY;
            enb_lock_q   <= 1'b0;
            gen_stop_q   <= 1'b0;
            pw_updated_q <= 1'b0;
            err_q        <= '0;
            stored_q     <= DEFAULT_PW;
        end else begin
            state_q      <= state_d;
            enb_lock_q   <= enb_lock_d;
            gen_stop_q   <= gen_stop_d;
            pw_updated_q <= pw_updated_d;
            err_q        <= err_d;
            stored_q     <= stored_d;
        end
    end

    assign enb_lock      = enb_lock_q;
    assign gen_stop      = gen_stop_q;
    assign pw_updated    = pw_updated_q;
    assign error_counter = err_q;
    assign digit_cnt     = (state_q == ST_SET || state_q == ST_COMMIT) ? set_cnt : ent_cnt;

endmodule

// File: tb/tb_d_module_passcheck.sv
// Scoreboard bench for d_module_passcheck: expected pulse/edge events queued by stimulus, checked by monitor.
// Latency: events are checked for the exact cycle they are expected in.
// Backpressure: n/a.
module tb_d_module_passcheck;

    localparam logic [1:0] EV_LOCK = 2'd0;
    localparam logic [1:0] EV_STOP = 2'd1;
    localparam logic [1:0] EV_UPD  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [2:0]  err;
    } ev_t;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic       key_set = 1'b0;
    logic       block_inp = 1'b0;
    logic       enb_set = 1'b0;
    logic       idle = 1'b0;
    logic       enb_lock, gen_stop, pw_updated;
    logic [2:0] error_counter, digit_cnt;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic lock_prev = 1'b0;
    ev_t  exp_q[$];

    d_module_passcheck dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_enter     (key_enter),
        .key_clear     (key_clear),
        .key_set       (key_set),
        .block_inp     (block_inp),
        .enb_set       (enb_set),
        .idle          (idle),
        .enb_lock      (enb_lock),
        .gen_stop      (gen_stop),
        .error_counter (error_counter),
        .digit_cnt     (digit_cnt),
        .pw_updated    (pw_updated)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents an event.
    task automatic mon_event(input logic [1:0] kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != 32'(cyc) || e.err != error_counter) begin
                errors++;
                $display("FAIL event: got kind %0d cycle %0d err %0d, expected kind %0d cycle %0d err %0d",
                         kind, cyc, error_counter, e.kind, e.cyc, e.err);
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (mon_en) begin
            if (gen_stop)               mon_event(EV_STOP);
            if (pw_updated)             mon_event(EV_UPD);
            if (enb_lock && !lock_prev) mon_event(EV_LOCK);
            lock_prev = enb_lock;
        end
    end

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic keys4(input logic [15:0] pw);
        for (int i = 3; i >= 0; i--) key(pw[i*4 +: 4]);
    endtask

    task automatic push(input logic [1:0] kind, input int at, input logic [2:0] err);
        ev_t e;
        e.kind = kind;
        e.cyc  = 32'(at);
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // kind_sel: 0 = pass (lock), 1 = fail (stop), 2 = set commit, 3 = no event.
    task automatic enter(input int kind_sel, input logic [2:0] err);
        if (kind_sel == 0) push(EV_LOCK, cyc + 2, 3'd0);
        if (kind_sel == 1) push(EV_STOP, cyc + 3, err);
        if (kind_sel == 2) push(EV_UPD, cyc + 2, 3'd0);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic pulse_idle();
        idle = 1'b1;
        tick();
        idle = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("reset_enb_lock", enb_lock, 0);
        chk("reset_gen_stop", gen_stop, 0);
        chk("reset_err", error_counter, 0);
        chk("reset_digit_cnt", digit_cnt, 0);
        chk("reset_pw_updated", pw_updated, 0);
        mon_en = 1'b1;

        // 1: default passcode accepted
        keys4(16'h1234);
        chk("t1_digit_cnt", digit_cnt, 4);
        enter(0, 3'd0);
        chk("t1_enb_lock", enb_lock, 1);
        chk("t1_err", error_counter, 0);
        pulse_idle();
        chk("t1_idle_lock", enb_lock, 0);
        chk("t1_idle_cnt", digit_cnt, 0);

        // 2: three wrong passcodes
        for (int i = 1; i <= 3; i++) begin
            keys4(16'h1235);
            enter(1, 3'(i));
        end
        chk("t2_enb_lock", enb_lock, 0);
        chk("t2_err", error_counter, 3);

        // 3: overflow, short entry, then clear and correct entry
        keys4(16'h1234);
        key(4'd5);
        chk("t3_ovf_cnt", digit_cnt, 4);
        enter(1, 3'd4);
        chk("t3_after_deny_cnt", digit_cnt, 0);
        key(4'd1); key(4'd2); key(4'd3);
        enter(1, 3'd5);
        key(4'd9);
        key(4'hC);
        chk("t3_bad_code_cnt", digit_cnt, 1);
        key_clear = 1'b1; tick(); key_clear = 1'b0;
        chk("t3_clear_cnt", digit_cnt, 0);
        keys4(16'h1234);
        enter(0, 3'd0);
        chk("t3_err_cleared", error_counter, 0);

        // 4: passcode change; short capture discarded first
        enb_set = 1'b1;
        key_set = 1'b1; tick(); key_set = 1'b0;
        key(4'd1); key(4'd2);
        chk("t4_set_cnt_short", digit_cnt, 2);
        enter(3, 3'd0);
        chk("t4_short_lock", enb_lock, 1);
        chk("t4_short_err", error_counter, 0);
        key_set = 1'b1; tick(); key_set = 1'b0;
        keys4(16'h9876);
        chk("t4_set_cnt", digit_cnt, 4);
        enter(2, 3'd0);
        chk("t4_commit_lock", enb_lock, 1);
        enb_set = 1'b0;
        pulse_idle();
        keys4(16'h1234);
        enter(1, 3'd1);
        keys4(16'h9876);
        enter(0, 3'd0);
        pulse_idle();

        // 5: blocked input, then idle beating key_enter
        block_inp = 1'b1;
        keys4(16'h9876);
        enter(3, 3'd0);
        block_inp = 1'b0;
        chk("t5_block_cnt", digit_cnt, 0);
        chk("t5_block_lock", enb_lock, 0);
        keys4(16'h9876);
        idle = 1'b1;
        key_enter = 1'b1;
        tick();
        idle = 1'b0;
        key_enter = 1'b0;
        tick(); tick(); tick();
        chk("t5_idle_lock", enb_lock, 0);
        chk("t5_idle_cnt", digit_cnt, 0);
        chk("t5_idle_err", error_counter, 0);

        // 6: saturation, then reset mid-entry restores default passcode
        for (int i = 1; i <= 8; i++) begin
            keys4(16'h1111);
            enter(1, (i > 7) ? 3'd7 : 3'(i));
        end
        chk("t6_err_sat", error_counter, 7);
        key(4'd9); key(4'd8);
        chk("t6_mid_cnt", digit_cnt, 2);
        pulse_reset();
        chk("t6_rst_err", error_counter, 0);
        chk("t6_rst_cnt", digit_cnt, 0);
        chk("t6_rst_lock", enb_lock, 0);
        chk("t6_rst_stop", gen_stop, 0);
        keys4(16'h1234);
        enter(0, 3'd0);
        chk("t6_default_pw", enb_lock, 1);

        tick(); tick();
        chk("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
